// File: rtl/charge_session_ctrl.sv
// charge_session_ctrl
//
// Session controller for the coin-operated charger. It tracks the paid amount
// and the remaining charge time as two-digit BCD values and counts the time
// down once charging starts. Every output comes straight from a register.
//
// Ports
//   clk         system clock (reduced 1000 Hz clock shared with the scanner)
//   rst_n       asynchronous active-low reset
//   power       single-cycle pulse, power/cancel button
//   coin        single-cycle pulse, one money unit inserted
//   start       single-cycle pulse, start-charging button
//   money_1/2   paid amount, BCD tens/ones
//   time_1/2    remaining time, BCD tens/ones
//   no_display  1 = display blanked
//   charging    1 = charger relay enabled
module charge_session_ctrl #(
  parameter int TICK_DIV      = 1000,
  parameter int MONEY_MAX     = 20,
  parameter int TIME_PER_COIN = 2,
  parameter int IDLE_TIMEOUT  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power,
  input  logic       coin,
  input  logic       start,
  output logic [3:0] money_1,
  output logic [3:0] money_2,
  output logic [3:0] time_1,
  output logic [3:0] time_2,
  output logic       no_display,
  output logic       charging
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);
  localparam logic [6:0]    MONEY_CAP  = 7'(MONEY_MAX);

  typedef enum logic [1:0] {S_OFF, S_IDLE, S_WAIT, S_CHARGING} state_e;

  state_e        state_q, state_d;
  logic [7:0]    money_q, money_d;
  logic [7:0]    time_q, time_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          no_display_q, no_display_d;
  logic          charging_q, charging_d;
  logic          tick;
  logic [6:0]    money_bin;
  logic [6:0]    money_inc;

  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    return {3'b000, b[7:4]} * 7'd10 + {3'b000, b[3:0]};
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 7'd10);
    o = 4'(v % 7'd10);
    return {t, o};
  endfunction

  // Bought time is clipped to what two digits can show.
  function automatic logic [7:0] money_to_time(input logic [6:0] m);
    int p;
    p = int'(m) * TIME_PER_COIN;
    if (p > 99) p = 99;
    return bin2bcd(7'(p));
  endfunction

  // Decimal borrow: x0 -> (x-1)9.
  function automatic logic [7:0] bcd_dec(input logic [7:0] b);
    if (b[3:0] == 4'd0) return {b[7:4] - 4'd1, 4'd9};
    return {b[7:4], b[3:0] - 4'd1};
  endfunction

  always_comb begin
    tick      = (presc_q == PRESC_LAST);
    money_bin = bcd2bin(money_q);
    // Coins past the cap are swallowed without changing anything.
    money_inc = (money_bin < MONEY_CAP) ? money_bin + 7'd1 : money_bin;

    state_d = state_q;
    money_d = money_q;
    time_d  = time_q;
    idle_d  = idle_q;

    case (state_q)
      S_OFF: begin
        if (power) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (tick) idle_d = idle_q + IW'(1);
        if (power) begin
          state_d = S_OFF;
        end else if (coin) begin
          state_d = S_WAIT;
          money_d = 8'h01;
          time_d  = money_to_time(7'd1);
        end else if (tick && (idle_q == IDLE_LAST)) begin
          state_d = S_OFF;
        end
      end
      S_WAIT: begin
        if (power) begin
          state_d = S_OFF;
          money_d = 8'h00;
          time_d  = 8'h00;
        end else begin
          // A coin arriving together with start still counts toward the session.
          if (coin) begin
            money_d = bin2bcd(money_inc);
            time_d  = money_to_time(money_inc);
          end
          if (start) state_d = S_CHARGING;
        end
      end
      S_CHARGING: begin
        // Inputs are ignored here: the session is locked until time runs out.
        if (tick) begin
          time_d = bcd_dec(time_q);
          if (time_q == 8'h01) begin
            state_d = S_IDLE;
            money_d = 8'h00;
          end
        end
      end
      default: state_d = S_OFF;
    endcase

    // Every state entry restarts the time base so the first tick lands a full
    // TICK_DIV cycles later.
    if (state_d != state_q) begin
      presc_d = '0;
      idle_d  = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    no_display_d = (state_d == S_OFF);
    charging_d   = (state_d == S_CHARGING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_OFF;
      money_q      <= 8'h00;
      time_q       <= 8'h00;
      presc_q      <= '0;
      idle_q       <= '0;
      no_display_q <= 1'b1;
      charging_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      money_q      <= money_d;
      time_q       <= time_d;
      presc_q      <= presc_d;
      idle_q       <= idle_d;
      no_display_q <= no_display_d;
      charging_q   <= charging_d;
    end
  end

  assign money_1    = money_q[7:4];
  assign money_2    = money_q[3:0];
  assign time_1     = time_q[7:4];
  assign time_2     = time_q[3:0];
  assign no_display = no_display_q;
  assign charging   = charging_q;

endmodule
